// File: rtl/calc_host_seq.sv
// calc_host_seq: host sequencer for the 8-bit CU/RB/ALU processor.
// It loads two operands from the switches on successive load-button presses,
// issues a one-cycle start pulse, follows the busy handshake, and holds the
// captured result for display.
module calc_host_seq #(
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn_load,
    input  logic              cu_busy,
    input  logic [DATA_W-1:0] cu_out,
    output logic [DATA_W-1:0] InA,
    output logic [DATA_W-1:0] InB,
    output logic              start,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              err,
    output logic [7:0]        op_count,
    output logic [2:0]        state_dbg
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_B     = 3'd1,
        S_ARM   = 3'd2,
        S_START = 3'd3,
        S_ACK   = 3'd4,
        S_RUN   = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic             btnS1;
    logic             btnS2;
    logic             btnS3;
    logic             loadPulse;
    logic [CNT_W-1:0] ackCnt;

    // Per-cycle strobes decoded by the FSM and applied by the datapath.
    logic loadA;
    logic loadB;
    logic captureRes;
    logic clearDone;
    logic setErr;
    logic clearErr;
    logic ackClr;
    logic ackInc;

    // Synchronise the raw button and keep one extra stage for edge detection.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btnS1 <= 1'b0;
            btnS2 <= 1'b0;
            btnS3 <= 1'b0;
        end else begin
            btnS1 <= btn_load;
            btnS2 <= btnS1;
            btnS3 <= btnS2;
        end
    end

    // One pulse per press, regardless of how long the button is held.
    assign loadPulse = btnS2 & ~btnS3;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and strobe decode; presses outside IDLE/B/DONE/ERR are dropped.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        stateNext  = state;
        loadA      = 1'b0;
        loadB      = 1'b0;
        captureRes = 1'b0;
        clearDone  = 1'b0;
        setErr     = 1'b0;
        clearErr   = 1'b0;
        ackClr     = 1'b0;
        ackInc     = 1'b0;
        case (state)
            S_IDLE: begin
                if (loadPulse) begin
                    loadA     = 1'b1;
                    stateNext = S_B;
                end
            end
            S_B: begin
                if (loadPulse) begin
                    loadB     = 1'b1;
                    stateNext = S_ARM;
                end
            end
            S_ARM: begin
                if (!cu_busy) begin
                    stateNext = S_START;
                end
            end
            S_START: begin
                ackClr    = 1'b1;
                stateNext = S_ACK;
            end
            S_ACK: begin
                if (cu_busy) begin
                    stateNext = S_RUN;
                end else if (ackCnt == CNT_LAST) begin
                    setErr    = 1'b1;
                    stateNext = S_ERR;
                end else begin
                    ackInc = 1'b1;
                end
            end
            S_RUN: begin
                if (!cu_busy) begin
                    captureRes = 1'b1;
                    stateNext  = S_DONE;
                end
            end
            S_DONE: begin
                if (loadPulse) begin
                    clearDone = 1'b1;
                    stateNext = S_IDLE;
                end
            end
            S_ERR: begin
                if (loadPulse) begin
                    clearErr  = 1'b1;
                    stateNext = S_IDLE;
                end
            end
            default: stateNext = S_IDLE;
        endcase
    end

    // Registered datapath: operands, start flop, result capture, flags, counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InA      <= '0;
            InB      <= '0;
            start    <= 1'b0;
            result   <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            op_count <= 8'd0;
            ackCnt   <= '0;
        end else begin
            // High exactly for the single cycle spent in S_START.
            start <= (stateNext == S_START);
            if (loadA) begin
                InA <= sw;
            end
            if (loadB) begin
                InB <= sw;
            end
            if (ackClr) begin
                ackCnt <= '0;
            end else if (ackInc) begin
                ackCnt <= ackCnt + CNT_W'(1);
            end
            if (captureRes) begin
                result   <= cu_out;
                done     <= 1'b1;
                op_count <= op_count + 8'd1;
            end else if (clearDone) begin
                done <= 1'b0;
            end
            if (setErr) begin
                err <= 1'b1;
            end else if (clearErr) begin
                err <= 1'b0;
            end
        end
    end

    // The state register itself drives the LEDs.
    assign state_dbg = state;

endmodule
